// File: rtl/strobe_pacer.sv
// -----------------------------------------------------------------------------
// strobe_pacer
//
// Purpose:
//    Turns a stream of single-cycle events (strb_in, back-to-back allowed) into
//    paced single-cycle pulses on strb_out.  Consecutive pulses are separated by
//    at least GAP LOW cycles, so that a slower clock domain can safely pick them
//    up through a cdc_strobe.  Events that arrive faster than they can be
//    emitted are queued in the pending counter.  When that counter is full, new
//    events are dropped and the counter saturates; it never wraps.
//
// Parameters:
//    CNT_W : pending-event counter width (2..16)
//    GAP   : minimum number of strb_out LOW cycles between two pulses (1..15)
//
// Ports:
//    clk      in   single clock, rising edge
//    arst     in   asynchronous reset, active-high
//    strb_in  in   event input, one event per HIGH cycle
//    strb_out out  paced single-cycle strobe (registered)
//    pending  out  accepted events not yet emitted (registered)
//    busy     out  HIGH while events are queued or the gap timer is running
//    ovf_clr  in   synchronous clear of ovf     (only with STROBE_PACER_OVF_EN)
//    ovf      out  sticky "event dropped" flag  (only with STROBE_PACER_OVF_EN)
//
// Configuration:
//    Define STROBE_PACER_OVF_EN to add the ovf/ovf_clr overflow-flag ports.
//    Without it, drops still saturate silently.
// -----------------------------------------------------------------------------
module strobe_pacer #(
   parameter int CNT_W = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             strb_in,
   output logic             strb_out,
   output logic [CNT_W-1:0] pending,
   output logic             busy
`ifdef STROBE_PACER_OVF_EN
   ,
   input  logic             ovf_clr,
   output logic             ovf
`endif
);

   localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [3:0]       GAP_LD   = 4'(GAP);

   // READY when the gap timer has expired, HOLD while it counts down.
   typedef enum logic {READY = 1'b0, HOLD = 1'b1} state_t;

   state_t           state;
   logic [3:0]       gap_cnt;
   logic [3:0]       gap_nxt;
   logic [CNT_W-1:0] pending_nxt;
   logic             strb_nxt;
   logic             fire;
   logic             drop;
   logic             accept;
`ifdef STROBE_PACER_OVF_EN
   logic             ovf_nxt;
`endif

   // Saturating pending update.  An increment at full scale is ignored.  An
   // arrival and an emission in the same cycle cancel out.
   function automatic logic [CNT_W-1:0] pend_update(input logic [CNT_W-1:0] cur,
                                                    input logic             inc,
                                                    input logic             dec);
      logic [CNT_W-1:0] res;
      res = cur;
      if (inc && !dec && (cur != PEND_MAX))
         res = cur + PEND_ONE;
      else if (dec && !inc)
         res = cur - PEND_ONE;
      return res;
   endfunction

   // State register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         strb_out <= 1'b0;
         pending  <= '0;
         gap_cnt  <= 4'd0;
`ifdef STROBE_PACER_OVF_EN
         ovf      <= 1'b0;
`endif
      end else begin
         strb_out <= strb_nxt;
         pending  <= pending_nxt;
         gap_cnt  <= gap_nxt;
`ifdef STROBE_PACER_OVF_EN
         ovf      <= ovf_nxt;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state = (gap_cnt == 4'd0) ? READY : HOLD;

      // strb_in is a same-cycle bypass.  An idle pacer fires on the edge that
      // samples the event, so pending never has to go negative.
      fire   = (state == READY) && ((pending != '0) || strb_in);
      drop   = strb_in && !fire && (pending == PEND_MAX);
      accept = strb_in && !drop;

      strb_nxt = fire;

      gap_nxt = gap_cnt;
      if (fire)
         gap_nxt = GAP_LD;
      else if (state == HOLD)
         gap_nxt = gap_cnt - 4'd1;

      pending_nxt = pend_update(pending, accept, fire);

`ifdef STROBE_PACER_OVF_EN
      // If a new drop and a clear arrive together, the drop wins.
      ovf_nxt = drop | (ovf & ~ovf_clr);
`endif
   end

   // Outputs
   always_comb begin
      busy = (pending != '0) || (gap_cnt != 4'd0);
   end

endmodule

// File: tb/tb_strobe_pacer.sv
`timescale 1ns/1ps
module tb_strobe_pacer;

   localparam int CW_A  = 4;
   localparam int GAP_A = 1;
   localparam int CW_B  = 2;
   localparam int GAP_B = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            arst_a, arst_b;
   logic            strb_a, strb_b;
   logic            out_a, out_b;
   logic            busy_a, busy_b;
   logic [CW_A-1:0] pend_a;
   logic [CW_B-1:0] pend_b;
`ifdef STROBE_PACER_OVF_EN
   logic            clr_a, clr_b;
   logic            ovf_a, ovf_b;
`endif

   strobe_pacer #(.CNT_W(CW_A), .GAP(GAP_A)) dut_a (
      .clk(clk), .arst(arst_a), .strb_in(strb_a), .strb_out(out_a),
      .pending(pend_a), .busy(busy_a)
`ifdef STROBE_PACER_OVF_EN
      , .ovf_clr(clr_a), .ovf(ovf_a)
`endif
   );

   strobe_pacer #(.CNT_W(CW_B), .GAP(GAP_B)) dut_b (
      .clk(clk), .arst(arst_b), .strb_in(strb_b), .strb_out(out_b),
      .pending(pend_b), .busy(busy_b)
`ifdef STROBE_PACER_OVF_EN
      , .ovf_clr(clr_b), .ovf(ovf_b)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model.  Each event is counted into a backlog.  A pulse may leave
   // only when more than GAP edges have passed since the previous pulse.  The
   // fire/drop decision and the gap timing are derived from edge indices.
   // ---------------------------------------------------------------------------
   int  ma_back, ma_last, ma_edge;  bit ma_out, ma_busy;
   int  mb_back, mb_last, mb_edge;  bit mb_out, mb_busy;
`ifdef STROBE_PACER_OVF_EN
   bit  ma_ovf, mb_ovf;
`endif
   int  ins_a, drops_a, pulses_a;
   int  ins_b, drops_b, pulses_b;

   task automatic step(input int gap, input int maxp, input bit in,
                       inout int back, inout int last, inout int edg,
                       output bit fire, output bit drop, output bit bsy);
      edg++;
      fire = ((edg - last) >= gap + 1) && (back > 0 || in);
      drop = in && !fire && (back == maxp);
      if (in && !drop) back++;
      if (fire) begin
         back--;
         last = edg;
      end
      bsy = (back != 0) || ((edg - last) < gap);
   endtask

   // The compare process runs once per cycle, on the falling edge.  It first
   // compares the DUT outputs with the model state.  It then advances the model
   // with the inputs that the next rising edge will sample.
   initial begin : compare
      int  ncyc;
      int  lpa, lpb;
      bit  f, d, b;
      ncyc = 0; lpa = -1; lpb = -1;
      ma_back = 0; ma_last = -1000; ma_edge = 0; ma_out = 0; ma_busy = 0;
      mb_back = 0; mb_last = -1000; mb_edge = 0; mb_out = 0; mb_busy = 0;
`ifdef STROBE_PACER_OVF_EN
      ma_ovf = 0; mb_ovf = 0;
`endif
      ins_a = 0; drops_a = 0; pulses_a = 0;
      ins_b = 0; drops_b = 0; pulses_b = 0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (arst_a) begin
            ma_back = 0; ma_last = ma_edge - 1000; ma_out = 0; ma_busy = 0;
`ifdef STROBE_PACER_OVF_EN
            ma_ovf = 0;
`endif
         end
         if (arst_b) begin
            mb_back = 0; mb_last = mb_edge - 1000; mb_out = 0; mb_busy = 0;
`ifdef STROBE_PACER_OVF_EN
            mb_ovf = 0;
`endif
         end

         check("a_strb_out", 32'(out_a),  32'(ma_out));
         check("a_pending",  32'(pend_a), 32'(ma_back));
         check("a_busy",     32'(busy_a), 32'(ma_busy));
         check("b_strb_out", 32'(out_b),  32'(mb_out));
         check("b_pending",  32'(pend_b), 32'(mb_back));
         check("b_busy",     32'(busy_b), 32'(mb_busy));
`ifdef STROBE_PACER_OVF_EN
         check("a_ovf", 32'(ovf_a), 32'(ma_ovf));
         check("b_ovf", 32'(ovf_b), 32'(mb_ovf));
`endif

         if (arst_a) lpa = -1;
         else if (out_a === 1'b1) begin
            pulses_a++;
            if (lpa >= 0) check("a_pulse_spacing_ok", 32'((ncyc - lpa) >= GAP_A + 1), 32'd1);
            lpa = ncyc;
         end
         if (arst_b) lpb = -1;
         else if (out_b === 1'b1) begin
            pulses_b++;
            if (lpb >= 0) check("b_pulse_spacing_ok", 32'((ncyc - lpb) >= GAP_B + 1), 32'd1);
            lpb = ncyc;
         end

         if (!arst_a) begin
            step(GAP_A, (1 << CW_A) - 1, strb_a, ma_back, ma_last, ma_edge, f, d, b);
            ma_out = f; ma_busy = b;
            ins_a += int'(strb_a); drops_a += int'(d);
`ifdef STROBE_PACER_OVF_EN
            ma_ovf = d | (ma_ovf & !clr_a);
`endif
         end
         if (!arst_b) begin
            step(GAP_B, (1 << CW_B) - 1, strb_b, mb_back, mb_last, mb_edge, f, d, b);
            mb_out = f; mb_busy = b;
            ins_b += int'(strb_b); drops_b += int'(d);
`ifdef STROBE_PACER_OVF_EN
            mb_ovf = d | (mb_ovf & !clr_b);
`endif
         end
      end
   end

   // Drive the inputs for one cycle shortly after the rising edge, then return
   // on the falling edge.  The outputs seen there reflect the previous cycle.
   task automatic tick(input bit sa, input bit sb);
      @(posedge clk);
      #2;
      strb_a = sa;
      strb_b = sb;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int exp_out [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
      int exp_pend[8] = '{0, 0, 1, 1, 2, 1, 1, 0};
      int cnt, i0, d0, p0, j0, e0, q0;

      strb_a = 0; strb_b = 0;
      arst_a = 0; arst_b = 0;
`ifdef STROBE_PACER_OVF_EN
      clr_a = 0; clr_b = 0;
`endif
      #1;
      arst_a = 1; arst_b = 1;
      #2;
      check("rst_strb_out", 32'(out_a),  32'd0);
      check("rst_pending",  32'(pend_a), 32'd0);
      check("rst_busy",     32'(busy_a), 32'd0);
`ifdef STROBE_PACER_OVF_EN
      check("rst_ovf",      32'(ovf_a),  32'd0);
`endif
      repeat (2) @(posedge clk);
      #2;
      arst_a = 0; arst_b = 0;
      repeat (3) tick(0, 0);

      // Single event: one pulse one cycle later, pending stays 0
      tick(1, 0);
      tick(0, 0);
      check("single_strb_out", 32'(out_a),  32'd1);
      check("single_busy",     32'(busy_a), 32'd1);
      check("single_pending",  32'(pend_a), 32'd0);
      tick(0, 0);
      check("single_strb_out_after", 32'(out_a),  32'd0);
      check("single_busy_after",     32'(busy_a), 32'd0);

      // Four back-to-back events, GAP=1
      tick(0, 0);
      for (int k = 0; k < 8; k++) begin
         tick(k < 4, 0);
         check($sformatf("burst4_strb_out[%0d]", k), 32'(out_a),  32'(exp_out[k]));
         check($sformatf("burst4_pending[%0d]", k),  32'(pend_a), 32'(exp_pend[k]));
      end

      // Build up a backlog of 5, then reset asynchronously
      repeat (2) tick(0, 0);
      for (int k = 0; k < 10; k++) tick(1, 0);
      tick(0, 0);
      check("prerst_pending", 32'(pend_a), 32'd5);
      #1;
      arst_a = 1;
      #1;
      check("arst_strb_out", 32'(out_a),  32'd0);
      check("arst_pending",  32'(pend_a), 32'd0);
      check("arst_busy",     32'(busy_a), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2;
      arst_a = 0;
      @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         tick(0, 0);
         cnt += int'(out_a);
      end
      check("postrst_pulses", 32'(cnt), 32'd0);
      tick(1, 0);
      tick(0, 0);
      check("postrst_fire", 32'(out_a), 32'd1);

      // GAP=3, CNT_W=2: ten back-to-back events
      cnt = 0;
      for (int k = 0; k < 25; k++) begin
         tick(0, k < 10);
         check($sformatf("sat_strb_out[%0d]", k), 32'(out_b),
               32'(((k % 4) == 1) && (k <= 21)));
         cnt += int'(out_b);
         if (k == 4) check("sat_pending_max", 32'(pend_b), 32'd3);
`ifdef STROBE_PACER_OVF_EN
         if (k == 5) check("sat_ovf_before_drop", 32'(ovf_b), 32'd0);
         if (k == 6) check("sat_ovf_first_drop",  32'(ovf_b), 32'd1);
`endif
      end
      check("sat_pulse_count", 32'(cnt), 32'd6);

`ifdef STROBE_PACER_OVF_EN
      // Overflow clear alone, then clear coinciding with a drop
      check("ovf_sticky", 32'(ovf_b), 32'd1);
      @(posedge clk); #2; clr_b = 1; @(negedge clk);
      @(posedge clk); #2; clr_b = 0; @(negedge clk);
      check("ovf_cleared", 32'(ovf_b), 32'd0);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #2;
         strb_b = 1;
         clr_b  = (k == 6);
         @(negedge clk);
         if (k == 6) check("ovf_set_before_clr", 32'(ovf_b), 32'd1);
      end
      tick(0, 0);
      clr_b = 0;
      check("ovf_set_wins", 32'(ovf_b), 32'd1);
      repeat (25) tick(0, 0);
`endif

      // Random traffic on both instances, then drain
      repeat (5) tick(0, 0);
      @(posedge clk); #2;
      i0 = ins_a; d0 = drops_a; p0 = pulses_a;
      j0 = ins_b; e0 = drops_b; q0 = pulses_b;
      @(negedge clk);
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #2;
         strb_a = ($urandom_range(0, 99) < 60);
         strb_b = ($urandom_range(0, 99) < 40);
`ifdef STROBE_PACER_OVF_EN
         clr_a = ($urandom_range(0, 99) < 5);
         clr_b = ($urandom_range(0, 99) < 5);
`endif
         @(negedge clk);
      end
`ifdef STROBE_PACER_OVF_EN
      clr_a = 0; clr_b = 0;
`endif
      repeat (80) tick(0, 0);
      check("a_idle_after_drain", 32'(busy_a), 32'd0);
      check("b_idle_after_drain", 32'(busy_b), 32'd0);
      check("a_conservation", 32'((pulses_a - p0) + (drops_a - d0)), 32'(ins_a - i0));
      check("b_conservation", 32'((pulses_b - q0) + (drops_b - e0)), 32'(ins_b - j0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
